// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: shared opcodes, instruction type, sequencer state and
// fault-code encodings, plus small opcode decode helpers for the sequencer.
package instr_sequencer_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef logic [31:0] instruction_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WAIT_X = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    FC_NONE          = 2'd0,
    FC_FETCH_TIMEOUT = 2'd1,
    FC_MISALIGNED    = 2'd2,
    FC_EXEC_TIMEOUT  = 2'd3
  } fault_code_t;

  // Control-flow instructions are the ones the branch_controller acts on.
  function automatic logic is_ctrl_flow(input instruction_t i);
    return (i[6:0] == OP_JAL) || (i[6:0] == OP_JALR) || (i[6:0] == OP_BRANCH);
  endfunction

  // Only JAL/JALR write a link register.
  function automatic logic is_link(input instruction_t i);
    return (i[6:0] == OP_JAL) || (i[6:0] == OP_JALR);
  endfunction

endpackage

// File: rtl/instr_sequencer_timeout.sv
// seq_timeout_counter: 8-bit wait timer shared by the fetch and execute waits.
// Ports: clk/rst (async active-low), clr (zero the count, wins over en),
//        en (count this cycle), limit (timeout length in cycles),
//        at_limit (the current cycle is the limit-th waiting cycle).
module seq_timeout_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       at_limit
);

  logic [7:0] count_q, count_d;

  // Next count: clear on state entry, otherwise advance while waiting.
  always_comb begin
    if (clr) begin
      count_d = 8'd0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q waiting cycles already elapsed, so this one is number count_q+1.
  assign at_limit = ((count_q + 8'd1) == limit);

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control sequencer (FETCH, EXEC, WAIT_X, UPDATE)
// owning the architectural PC, halt/run control and fault reporting.
// Ports: clk, rst (async active-low); run/halt_req control levels;
//        imem_req/imem_addr/imem_ack/imem_rdata fetch handshake;
//        instr/pc current instruction and its PC;
//        bc_step/bc_enable/bc_pc_out/bc_ret_addr branch_controller interface;
//        exec_step/exec_done execute-unit handshake;
//        link_we/link_rd/link_data JAL/JALR link write;
//        busy/halted/fault/fault_code status. All outputs are registered.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16,
  parameter int          EXEC_TIMEOUT  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         halt_req,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output instruction_t instr,
  output logic [31:0]  pc,
  output logic         bc_step,
  output logic         bc_enable,
  input  logic [31:0]  bc_pc_out,
  input  logic [31:0]  bc_ret_addr,
  output logic         exec_step,
  input  logic         exec_done,
  output logic         link_we,
  output logic [4:0]   link_rd,
  output logic [31:0]  link_data,
  output logic         busy,
  output logic         halted,
  output logic         fault,
  output logic [1:0]   fault_code
);

  localparam logic [7:0] FETCH_LIMIT = 8'(FETCH_TIMEOUT);
  localparam logic [7:0] EXEC_LIMIT  = 8'(EXEC_TIMEOUT);

  seq_state_t   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  instruction_t instr_q, instr_d;
  logic [31:0]  link_data_q, link_data_d;
  fault_code_t  fault_code_q, fault_code_d;
  logic imem_req_q, imem_req_d, bc_step_q, bc_step_d, exec_step_q, exec_step_d;
  logic bc_enable_q, bc_enable_d, link_we_q, link_we_d, busy_q, busy_d;
  logic halted_q, halted_d, fault_q, fault_d, done_seen_q, done_seen_d;
  logic wait_done, tmr_clr, tmr_en, tmr_at_limit;
  logic [7:0] tmr_limit;

  // exec_done seen during EXEC is remembered so WAIT_X can honour it.
  assign wait_done = exec_done | done_seen_q;
  assign tmr_en    = ((state_q == ST_FETCH) && !imem_ack) ||
                     ((state_q == ST_WAIT_X) && !wait_done);
  assign tmr_limit = (state_q == ST_WAIT_X) ? EXEC_LIMIT : FETCH_LIMIT;
  assign tmr_clr   = (state_d != state_q);

  seq_timeout_counter u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .limit    (tmr_limit),
    .at_limit (tmr_at_limit)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    fault_code_d = fault_code_q;
    link_data_d  = link_data_q;
    link_we_d    = 1'b0;
    done_seen_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end else if (tmr_at_limit) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_FETCH_TIMEOUT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        done_seen_d = exec_done;
        state_d     = ST_WAIT_X;
      end
      ST_WAIT_X: begin
        if (wait_done) begin
          state_d     = ST_UPDATE;
          // Link strobe is issued in UPDATE, so decide it on the way in;
          // a misaligned target suppresses it.
          link_we_d   = is_link(instr_q) && (instr_q[11:7] != 5'd0) &&
                        (bc_pc_out[1:0] == 2'b00);
          link_data_d = bc_ret_addr;
        end else if (tmr_at_limit) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_EXEC_TIMEOUT;
        end else begin
          state_d = ST_WAIT_X;
        end
      end
      ST_UPDATE: begin
        if (bc_pc_out[1:0] != 2'b00) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_MISALIGNED;
        end else begin
          pc_d = bc_pc_out;
          if (halt_req) begin
            state_d = ST_HALT;
          end else if (run) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        if (run && !halt_req) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    // Outputs are registered: decode them from the state being entered.
    imem_req_d  = (state_d == ST_FETCH);
    bc_step_d   = (state_d == ST_EXEC);
    exec_step_d = (state_d == ST_EXEC);
    bc_enable_d = is_ctrl_flow(instr_d);
    busy_d      = (state_d == ST_FETCH) || (state_d == ST_EXEC) ||
                  (state_d == ST_WAIT_X) || (state_d == ST_UPDATE);
    halted_d    = (state_d == ST_HALT);
    fault_d     = fault_q | (state_d == ST_FAULT);
  end

  // State, PC, instruction and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0000_0000;
      link_data_q  <= 32'h0000_0000;
      fault_code_q <= FC_NONE;
      imem_req_q   <= 1'b0;
      bc_step_q    <= 1'b0;
      exec_step_q  <= 1'b0;
      bc_enable_q  <= 1'b0;
      link_we_q    <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      done_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      link_data_q  <= link_data_d;
      fault_code_q <= fault_code_d;
      imem_req_q   <= imem_req_d;
      bc_step_q    <= bc_step_d;
      exec_step_q  <= exec_step_d;
      bc_enable_q  <= bc_enable_d;
      link_we_q    <= link_we_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
      done_seen_q  <= done_seen_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign instr      = instr_q;
  assign pc         = pc_q;
  assign bc_step    = bc_step_q;
  assign bc_enable  = bc_enable_q;
  assign exec_step  = exec_step_q;
  assign link_we    = link_we_q;
  assign link_rd    = instr_q[11:7];
  assign link_data  = link_data_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule
